// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // The bit counter must also hold WIDTH itself after the last increment.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = x - y - bin, bout = borrow out.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor, LSB first, with start/busy/done handshake.
// Optional two's-complement overflow output: define SUB_OVERFLOW_EN.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef SUB_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bor_q, bor_d;
    logic             borrow_q, borrow_d;
`ifdef SUB_OVERFLOW_EN
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             ovf_q, ovf_d;
`endif

    logic cell_d;
    logic cell_bout;

    full_subtractor u_cell (
        .x    (a_sh_q[0]),
        .y    (b_sh_q[0]),
        .bin  (bor_q),
        .d    (cell_d),
        .bout (cell_bout)
    );

    always_comb begin
        // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latches).
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_d    = res_q;
        diff_d   = diff_q;
        cnt_d    = cnt_q;
        bor_d    = bor_q;
        borrow_d = borrow_q;
`ifdef SUB_OVERFLOW_EN
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        ovf_d    = ovf_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    state_d = RUN;
                    a_sh_d  = a;
                    b_sh_d  = b;
                    bor_d   = 1'b0;
                    cnt_d   = '0;
`ifdef SUB_OVERFLOW_EN
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
`endif
                end
            end
            RUN: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                res_d  = {cell_d, res_q[WIDTH-1:1]};
                bor_d  = cell_bout;
                cnt_d  = cnt_q + 1'b1;
                // Results are loaded on the edge into DONE so they are visible while done is high.
                if (cnt_q == LAST_BIT) begin
                    state_d  = DONE;
                    diff_d   = {cell_d, res_q[WIDTH-1:1]};
                    borrow_d = cell_bout;
`ifdef SUB_OVERFLOW_EN
                    ovf_d    = (a_msb_q != b_msb_q) && (cell_d != a_msb_q);
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only; the shift registers are
        // small and explicitly cleared, so reset covers every flop.
        if (rst) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_q    <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            bor_q    <= 1'b0;
            borrow_q <= 1'b0;
`ifdef SUB_OVERFLOW_EN
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_q    <= res_d;
            diff_q   <= diff_d;
            cnt_q    <= cnt_d;
            bor_q    <= bor_d;
            borrow_q <= borrow_d;
`ifdef SUB_OVERFLOW_EN
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign busy   = (state_q == RUN);
    assign done   = (state_q == DONE);
    assign diff   = diff_q;
    assign borrow = borrow_q;
`ifdef SUB_OVERFLOW_EN
    assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8); checks ovf when SUB_OVERFLOW_EN is defined.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a, b;
    logic         busy, done, borrow;
    logic [W-1:0] diff;
`ifdef SUB_OVERFLOW_EN
    logic         ovf;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow)
`ifdef SUB_OVERFLOW_EN
        ,
        .ovf    (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Waits (from #1 after an edge) until done is high; counts edges and busy cycles.
    task automatic wait_done(inout int lat, output int busy_cycles);
        busy_cycles = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) busy_cycles++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    // Issues one operation; returns edges from the accepting edge (inclusive) to done.
    task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                         output int lat, output int busy_cycles);
        @(negedge clk);
        a = ia; b = ib; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        wait_done(lat, busy_cycles);
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] d;
        logic         bor;
        logic         ovf;
    } vec_t;

    vec_t vecs[7] = '{
        '{8'h5A, 8'h23, 8'h37, 1'b0, 1'b0},
        '{8'h10, 8'h20, 8'hF0, 1'b1, 1'b0},
        '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0},
        '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0},
        '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0},
        '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1},
        '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0}
    };

    initial begin
        int lat, bcyc;
        bit saw_done;

        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",   busy,   0);
        check("rst_done",   done,   0);
        check("rst_diff",   diff,   0);
        check("rst_borrow", borrow, 0);
`ifdef SUB_OVERFLOW_EN
        check("rst_ovf",    ovf,    0);
`endif
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            do_op(vecs[i].a, vecs[i].b, lat, bcyc);
            check($sformatf("v%0d_latency", i), lat, W + 1);
            check($sformatf("v%0d_busy_cycles", i), bcyc, W);
            check($sformatf("v%0d_diff", i), diff, vecs[i].d);
            check($sformatf("v%0d_borrow", i), borrow, vecs[i].bor);
`ifdef SUB_OVERFLOW_EN
            check($sformatf("v%0d_ovf", i), ovf, vecs[i].ovf);
`endif
            @(posedge clk); #1;
            check($sformatf("v%0d_done_pulse", i), done, 0);
            check($sformatf("v%0d_diff_hold", i), diff, vecs[i].d);
        end

        // Start held through RUN with changed operands, then a back-to-back start in DONE.
        @(negedge clk);
        a = 8'h40; b = 8'h01; start = 1'b1;
        @(posedge clk); #1;
        a = 8'hAA; b = 8'h55;
        lat = 1;
        wait_done(lat, bcyc);
        check("hold_latency", lat, W + 1);
        check("hold_diff", diff, 8'h3F);
        check("hold_borrow", borrow, 0);
        a = 8'h09; b = 8'h0A;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        check("b2b_busy", busy, 1);
        check("b2b_diff_stable", diff, 8'h3F);
        wait_done(lat, bcyc);
        check("b2b_latency", lat, W + 1);
        check("b2b_diff", diff, 8'hFF);
        check("b2b_borrow", borrow, 1);

        // Reset in the 4th RUN cycle aborts without a done pulse.
        @(negedge clk);
        a = 8'h5A; b = 8'h23; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy",   busy,   0);
        check("abort_done",   done,   0);
        check("abort_diff",   diff,   0);
        check("abort_borrow", borrow, 0);
        saw_done = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done === 1'b1) saw_done = 1'b1;
        end
        check("abort_no_done", saw_done, 0);
        do_op(8'h03, 8'h01, lat, bcyc);
        check("post_abort_latency", lat, W + 1);
        check("post_abort_diff", diff, 8'h02);
        check("post_abort_borrow", borrow, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
